// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the multicycle divider: FSM state encodings and
// handshake levels used by div_ctrl and the execute stage.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam int unsigned DoubleWordBus = 64;

endpackage

// File: rtl/div_ctrl_step.sv
// One radix-2 restoring division iteration: shift the next dividend bit into
// the partial remainder and keep the difference when no borrow occurs.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {r, q[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    // On a borrow the shifted value is below the divisor, so it fits WIDTH bits.
    if (!diff[WIDTH]) begin
      r_next = diff[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end else begin
      r_next = shifted[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Multicycle DIV/DIVU sequencer: latches operand magnitudes, runs WIDTH
// restoring iterations, applies sign fix-up and holds the result for execute.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  div_state_e state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [WIDTH-1:0]   r, r_n, q, q_n, dvs, dvs_n;
  logic               sa, sa_n, sb, sb_n;
  logic [2*WIDTH-1:0] result_n;
  logic               ready_n;
  logic [WIDTH-1:0]   step_r, step_q, q_fix, r_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r       (r),
    .q       (q),
    .divisor (dvs),
    .r_next  (step_r),
    .q_next  (step_q)
  );

  // Sign flags are only set for DIV, so DIVU passes through unchanged.
  assign q_fix = (sa ^ sb) ? -q : q;
  assign r_fix = sa ? -r : r;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    r_n      = r;
    q_n      = q;
    dvs_n    = dvs;
    sa_n     = sa;
    sb_n     = sb;
    result_n = result_o;
    ready_n  = ready_o;
    case (state)
      DIV_FREE: begin
        ready_n = DivResultNotReady;
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_n = DIV_BYZERO;
          end else begin
            state_n = DIV_ON;
            cnt_n   = '0;
            sa_n    = signed_div_i & opdata1_i[WIDTH-1];
            sb_n    = signed_div_i & opdata2_i[WIDTH-1];
            dvs_n   = (signed_div_i & opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
            q_n     = (signed_div_i & opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
            r_n     = '0;
          end
        end
      end
      DIV_BYZERO: begin
        result_n = '0;
        ready_n  = DivResultReady;
        state_n  = DIV_END;
      end
      DIV_ON: begin
        if (annul_i) begin
          state_n = DIV_FREE;
          ready_n = DivResultNotReady;
        end else if (cnt != LAST) begin
          r_n   = step_r;
          q_n   = step_q;
          cnt_n = cnt + 1'b1;
        end else begin
          result_n = {r_fix, q_fix};
          ready_n  = DivResultReady;
          state_n  = DIV_END;
        end
      end
      DIV_END: begin
        if (start_i == DivStop) begin
          state_n  = DIV_FREE;
          ready_n  = DivResultNotReady;
          result_n = '0;
        end
      end
      default: state_n = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      r        <= '0;
      q        <= '0;
      dvs      <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      r        <= r_n;
      q        <= q_n;
      dvs      <= dvs_n;
      sa       <= sa_n;
      sb       <= sb_n;
      result_o <= result_n;
      ready_o  <= ready_n;
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, signed/unsigned results, divide by
// zero, annul, mid-operation reset and back-to-back operations.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int vectors = 0;
  int miscompares = 0;

  div_ctrl #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Starts an operation and waits for ready_o; lat counts edges after the
  // sampling edge N (-1 on timeout). start_i is left high.
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic scramble, output int lat, output logic [63:0] res);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    lat          = -1;
    res          = 64'd0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (scramble && k == 5) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~s;
      end
      if (ready_o) begin
        lat = k;
        res = result_o;
        break;
      end
    end
  endtask

  task automatic end_op();
    start_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
    signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (result_o !== 64'd0) begin miscompares++; $display("FAIL reset_result got=%h want=0", result_o); end
    vectors++;
    if (ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_ready got=%b want=0", ready_o); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_divu();
    int lat;
    logic [63:0] res;
    run_div(1'b0, 32'd100, 32'd7, 1'b0, lat, res);
    vectors++;
    if (lat !== 33) begin miscompares++; $display("FAIL divu_latency got=%0d want=33", lat); end
    vectors++;
    if (res !== {32'd2, 32'd14}) begin miscompares++; $display("FAIL divu_result got=%h want=%h", res, {32'd2, 32'd14}); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (ready_o !== 1'b1 || result_o !== {32'd2, 32'd14}) begin
        miscompares++;
        $display("FAIL divu_hold got=%b/%h want=1/%h", ready_o, result_o, {32'd2, 32'd14});
      end
    end
    end_op();
    vectors++;
    if (ready_o !== 1'b0) begin miscompares++; $display("FAIL divu_drop_ready got=%b want=0", ready_o); end
    vectors++;
    if (result_o !== 64'd0) begin miscompares++; $display("FAIL divu_drop_result got=%h want=0", result_o); end
  endtask

  task automatic test_signed();
    int lat;
    logic [63:0] res;
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, res);
    vectors++;
    if (lat !== 33) begin miscompares++; $display("FAIL sdiv_neg_dividend_latency got=%0d want=33", lat); end
    vectors++;
    if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      miscompares++; $display("FAIL sdiv_neg_dividend got=%h want=ffffffff_fffffffd", res);
    end
    end_op();
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, lat, res);
    vectors++;
    if (lat !== 33) begin miscompares++; $display("FAIL sdiv_neg_divisor_latency got=%0d want=33", lat); end
    vectors++;
    if (res !== {32'd1, 32'hFFFF_FFFD}) begin
      miscompares++; $display("FAIL sdiv_neg_divisor got=%h want=00000001_fffffffd", res);
    end
    end_op();
  endtask

  task automatic test_extremes();
    int lat;
    logic [63:0] res;
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, res);
    vectors++;
    if (lat !== 33 || res !== {32'd0, 32'h8000_0000}) begin
      miscompares++; $display("FAIL min_by_minus1 got=%0d/%h want=33/00000000_80000000", lat, res);
    end
    end_op();
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, lat, res);
    vectors++;
    if (lat !== 33 || res !== {32'd0, 32'hFFFF_FFFF}) begin
      miscompares++; $display("FAIL max_by_one got=%0d/%h want=33/00000000_ffffffff", lat, res);
    end
    end_op();
  endtask

  task automatic test_div_zero();
    int lat;
    logic [63:0] res;
    for (int s = 0; s < 2; s++) begin
      run_div(s[0], (s == 0) ? 32'd5 : 32'hFFFF_FFFB, 32'd0, 1'b0, lat, res);
      vectors++;
      if (lat !== 1) begin miscompares++; $display("FAIL divzero_latency signed=%0d got=%0d want=1", s, lat); end
      vectors++;
      if (res !== 64'd0) begin miscompares++; $display("FAIL divzero_result signed=%0d got=%h want=0", s, res); end
      end_op();
    end
  endtask

  task automatic test_annul();
    int lat;
    logic [63:0] res;
    int rose;
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    rose = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o !== 1'b0) rose++;
      @(posedge clk);
      #1;
    end
    vectors++;
    if (rose !== 0) begin miscompares++; $display("FAIL annul_ready_high_cycles got=%0d want=0", rose); end
    run_div(1'b0, 32'd9, 32'd3, 1'b0, lat, res);
    vectors++;
    if (lat !== 33 || res !== {32'd0, 32'd3}) begin
      miscompares++; $display("FAIL annul_restart got=%0d/%h want=33/00000000_00000003", lat, res);
    end
    end_op();
  endtask

  task automatic test_reset_mid();
    int rose;
    signed_div_i = 1'b1; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (21) @(posedge clk);
    #1;
    rst = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      miscompares++; $display("FAIL reset_mid got=%b/%h want=0/0", ready_o, result_o);
    end
    rst = 1'b0;
    rose = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ready_o !== 1'b0) rose++;
    end
    vectors++;
    if (rose !== 0) begin miscompares++; $display("FAIL reset_mid_after got=%0d want=0", rose); end
  endtask

  task automatic test_back_to_back();
    logic        s_tab [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] a_tab [8] = '{32'd12345678, 32'hFFFF_FF9C, 32'h7FFF_FFFF, 32'h8000_0000,
                              32'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    logic [31:0] b_tab [8] = '{32'd1000, 32'd7, 32'hFFFF_FFFF, 32'd2,
                              32'd10, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF0};
    int lat;
    logic [63:0] res, exp;
    logic s;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) begin
        s = s_tab[i]; a = a_tab[i]; b = b_tab[i];
      end else begin
        s = 1'($urandom_range(0, 1));
        a = $urandom;
        b = (i[0]) ? $urandom : 32'($urandom_range(1, 300));
        if (b == 32'd0) b = 32'd1;
      end
      exp = ref_div(s, a, b);
      run_div(s, a, b, 1'b0, lat, res);
      vectors++;
      if (lat !== 33 || res !== exp) begin
        miscompares++;
        $display("FAIL b2b[%0d] s=%0d a=%h b=%h got=%0d/%h want=33/%h", i, s, a, b, lat, res, exp);
      end
      end_op();
    end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_extremes();
    test_div_zero();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
